// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared state type, round constants and helpers for the ASCON permutation
package ascon_pkg;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam logic [7:0] ASCON_RC [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } perm_state_e;

  localparam logic [3:0] ROUNDS_A  = 4'd12;
  localparam logic [3:0] ROUNDS_B6 = 4'd6;
  localparam logic [3:0] ROUNDS_B8 = 4'd8;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
    logic [127:0] d;
    d = {x, x} >> r;
    return d[63:0];
  endfunction

  // Indices past the table yield a zero constant rather than an X.
  function automatic logic [7:0] rc_at(input logic [3:0] idx);
    return (idx < 4'd12) ? ASCON_RC[idx] : 8'h00;
  endfunction

  function automatic logic [3:0] legal_rounds(input logic [3:0] r);
    case (r)
      ROUNDS_B6, ROUNDS_B8: return r;
      default:              return ROUNDS_A;
    endcase
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational ASCON round: constant add, bitsliced S-box, linear layer
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state,
  input  logic [7:0]   rc,
  output ascon_state_t result
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] s0, s1, s2, s3, s4;

  always_comb begin
    // Constant addition folded into the S-box input mixing.
    a0 = state.x0 ^ state.x4;
    a1 = state.x1;
    a2 = state.x2 ^ {56'd0, rc} ^ state.x1;
    a3 = state.x3;
    a4 = state.x4 ^ state.x3;

    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);

    s0 = b0 ^ b4;
    s1 = b1 ^ b0;
    s2 = ~b2;
    s3 = b3 ^ b2;
    s4 = b4;
  end

  assign result = '{
    x0: s0 ^ ror64(s0, 19) ^ ror64(s0, 28),
    x1: s1 ^ ror64(s1, 61) ^ ror64(s1, 39),
    x2: s2 ^ ror64(s2, 1)  ^ ror64(s2, 6),
    x3: s3 ^ ror64(s3, 10) ^ ror64(s3, 17),
    x4: s4 ^ ror64(s4, 7)  ^ ror64(s4, 41)
  };

endmodule

// File: rtl/ascon_perm_iter.sv
// rtl/ascon_perm_iter.sv - iterative handshaked ASCON p^a/p^b engine; ASCON_PERM_UNROLL2_EN chains two rounds per cycle
module ascon_perm_iter
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_x0,
  input  logic [63:0] in_x1,
  input  logic [63:0] in_x2,
  input  logic [63:0] in_x3,
  input  logic [63:0] in_x4,
  input  logic [3:0]  in_rounds,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_x0,
  output logic [63:0] out_x1,
  output logic [63:0] out_x2,
  output logic [63:0] out_x3,
  output logic [63:0] out_x4,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX = 4'(MAX_ROUNDS - 1);

  perm_state_e  st, st_nx;
  ascon_state_t s_q, s_nx, step, r1;
  logic [3:0]   rc_idx, rc_nx;
  logic [7:0]   rc0;
  logic         last;

  assign rc0 = rc_at(rc_idx);

  ascon_round u_round0 (.state(s_q), .rc(rc0), .result(r1));

`ifdef ASCON_PERM_UNROLL2_EN
  localparam logic [3:0] RC_STEP = 4'd2;
  ascon_state_t r2;
  logic [7:0]   rc1;
  assign rc1 = rc_at(rc_idx + 4'd1);
  ascon_round u_round1 (.state(r1), .rc(rc1), .result(r2));
  assign step = r2;
  // Legal round counts are even, so the pair ending on the last constant starts one below it.
  assign last = (rc_idx == LAST_IDX - 4'd1);
`else
  localparam logic [3:0] RC_STEP = 4'd1;
  assign step = r1;
  assign last = (rc_idx == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      s_q    <= '0;
      rc_idx <= 4'd0;
    end else begin
      st     <= st_nx;
      s_q    <= s_nx;
      rc_idx <= rc_nx;
    end
  end

  always_comb begin
    st_nx = st;
    s_nx  = s_q;
    rc_nx = rc_idx;
    case (st)
      IDLE: begin
        if (in_valid) begin
          s_nx  = '{x0: in_x0, x1: in_x1, x2: in_x2, x3: in_x3, x4: in_x4};
          rc_nx = 4'(MAX_ROUNDS) - legal_rounds(in_rounds);
          st_nx = RUN;
        end
      end
      RUN: begin
        s_nx  = step;
        rc_nx = rc_idx + RC_STEP;
        if (last) st_nx = DONE;
      end
      DONE: begin
        if (out_ready) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // The state register doubles as the output holding register between jobs.
  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);
  assign out_x0    = s_q.x0;
  assign out_x1    = s_q.x1;
  assign out_x2    = s_q.x2;
  assign out_x3    = s_q.x3;
  assign out_x4    = s_q.x4;

endmodule
